// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller. Keeps one instruction-memory
//               request in flight at most and presents fetched words to
//               decode through a valid/ready output register. Branch
//               redirects that arrive while a request is in flight set a
//               kill flag, so the stale read data is dropped when it returns.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN adds a sticky
//               align_err output for misaligned redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_imem_req;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_plus4;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  // Fetch FSM: PC, kill flag, memory request and the decode output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_imem_req <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'h0;
      r_if_pc    <= 32'h0;
      r_if_pc4   <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          if (imem_gnt) begin
            // A redirect coinciding with the grant means the accepted
            // request targets the old PC, so its data must be dropped.
            r_state    <= ST_WAIT;
            r_imem_req <= 1'b0;
            r_kill     <= redirect_valid;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redir_pc;
            if (imem_rvalid) begin
              r_kill     <= 1'b0;
              r_state    <= ST_REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_kill) begin
              r_kill     <= 1'b0;
              r_state    <= ST_REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_if_inst  <= imem_rdata;
              r_if_pc    <= r_pc;
              r_if_pc4   <= w_pc_plus4;
              r_if_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Redirect wins over a same-cycle handshake: the held word is
          // thrown away rather than consumed.
          if (redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_if_valid <= 1'b0;
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end else if (if_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_align_err;

  // Sticky flag: any loaded redirect target with nonzero low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_align_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_align_err <= 1'b1;
    end
  end

  assign align_err = r_align_err;
`endif

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A small memory model
//               answers requests; expected fetch PCs are queued by each
//               scenario and compared on every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err;
`endif

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_err      (align_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int hs_cyc_last = 0;
  int hs_cyc_prev = 0;

  // memory model state
  bit          gnt_en = 1'b0;
  bit          force_rv = 1'b0;
  int          mem_lat = 1;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  logic [31:0] exp_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic [31:0] a_addr;
    logic        a_gnt;
    logic        a_rv;
    logic [31:0] e_pc;
    imem_rvalid = (mem_pend && mem_cnt == 0) || force_rv;
    imem_rdata  = force_rv ? 32'hDEAD_BEEF : (imem_rvalid ? inst_of(mem_addr) : 32'h0);
    imem_gnt    = gnt_en && imem_req && !mem_pend;
    if (if_valid && if_ready && !redirect_valid) begin
      hs_cnt++;
      hs_cyc_prev = hs_cyc_last;
      hs_cyc_last = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_fetch: got if_pc=%h with no fetch expected", if_pc);
      end else begin
        e_pc = exp_q.pop_front();
        checks += 2;
        if (if_pc !== e_pc) begin
          failures++;
          $display("FAIL if_pc: got %h expected %h", if_pc, e_pc);
        end
        if (if_inst !== inst_of(e_pc)) begin
          failures++;
          $display("FAIL if_inst: got %h expected %h (pc %h)", if_inst, inst_of(e_pc), e_pc);
        end
        if (if_pc4 !== e_pc + 32'd4) begin
          failures++;
          $display("FAIL if_pc4: got %h expected %h", if_pc4, e_pc + 32'd4);
        end
      end
    end
    a_addr = imem_addr;
    a_gnt  = imem_gnt;
    a_rv   = imem_rvalid && !force_rv;
    @(posedge clk);
    if (a_rv) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (a_gnt) begin
      mem_pend = 1'b1;
      mem_addr = a_addr;
      mem_cnt  = mem_lat - 1;
    end
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int target;
    target = hs_cnt + n;
    while (hs_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (hs_cnt < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d handshakes expected %0d", tag, hs_cnt, target);
    end
  endtask

  // Steps until the DUT sits in WAIT with the request outstanding.
  task automatic goto_wait(input string tag);
    int budget;
    budget = 30;
    while (!(mem_pend && !imem_req && !if_valid) && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL %s_wait_timeout: got no outstanding request expected one", tag);
    end
  endtask

  task automatic wait_if_valid(input string tag);
    int budget;
    budget = 30;
    while (!if_valid && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (!if_valid) begin
      failures++;
      $display("FAIL %s_valid_timeout: got if_valid=0 expected 1", tag);
    end
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h expected req=1 addr=%h", tag, imem_req, imem_addr, addr);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_inst !== 32'h0 ||
        if_pc !== 32'h0 || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h expected all zero",
               tag, imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_align_err: got %b expected 0", tag, align_err);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b1;
  endtask

  task automatic test_stream();
    if_ready = 1'b1;
    gnt_en = 1'b1;
    mem_lat = 1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_req: got %b expected 0", imem_req);
    end
    step();
    check_req("first_req", 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    run_until_pops(3, 40, "stream");
    checks++;
    if (hs_cyc_last - hs_cyc_prev != 3) begin
      failures++;
      $display("FAIL stream_rate: got %0d cycles per fetch expected 3", hs_cyc_last - hs_cyc_prev);
    end
  endtask

  task automatic test_hold_stall();
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    if_ready = 1'b0;
    wait_if_valid("stall");
    s_inst = if_inst;
    s_pc   = if_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_inst !== s_inst || if_pc !== s_pc || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable: got valid=%b inst=%h pc=%h req=%b expected 1 %h %h 0",
                 if_valid, if_inst, if_pc, imem_req, s_inst, s_pc);
      end
    end
    exp_q.push_back(32'hC);
    if_ready = 1'b1;
    run_until_pops(1, 5, "stall");
  endtask

  task automatic test_redirect_wait();
    int budget;
    mem_lat = 3;
    goto_wait("rw");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    budget = 20;
    while (!imem_req && budget > 0) begin
      step();
      budget--;
    end
    check_req("redirect_wait_addr", 32'h100);
    exp_q.push_back(32'h100);
    run_until_pops(1, 20, "rw");
    // redirect arriving together with the read data
    mem_lat = 1;
    goto_wait("rwv");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    check_req("redirect_rvalid_addr", 32'h200);
    exp_q.push_back(32'h200);
    run_until_pops(1, 20, "rwv");
  endtask

  task automatic test_redirect_hold();
    if_ready = 1'b0;
    wait_if_valid("rh");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    if_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_hold_valid: got %b expected 0", if_valid);
    end
    check_req("redirect_hold_addr", 32'h300);
    exp_q.push_back(32'h300);
    run_until_pops(1, 20, "rh");
  endtask

  task automatic test_redirect_req();
    gnt_en = 1'b0;
    check_req("req_before_redirect", 32'h304);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    step();
    check_req("redirect_req_nogrant", 32'h400);
    gnt_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0500;
    step();
    exp_q.push_back(32'h500);
    run_until_pops(1, 20, "rq");
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    run_until_pops(2, 30, "wrap");
  endtask

  task automatic test_misalign();
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_err !== 1'b0) begin
      failures++;
      $display("FAIL align_err_pre: got %b expected 0", align_err);
    end
`endif
    gnt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    check_req("misalign_addr", 32'h100);
    gnt_en = 1'b1;
    exp_q.push_back(32'h100);
    run_until_pops(1, 20, "mis");
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (align_err !== 1'b1) begin
      failures++;
      $display("FAIL align_err_sticky: got %b expected 1", align_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    goto_wait("rst");
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    mem_pend = 1'b0;
    reset = 1'b1;
    force_rv = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle_req: got %b expected 0", imem_req);
    end
    step();
    force_rv = 1'b0;
    mem_lat = 1;
    check_req("reset_mid_restart", 32'h0);
    exp_q.push_back(32'h0);
    run_until_pops(1, 20, "rst");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_misalign();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-005 SHALL have port redirect_pc  input  32  redirect target, valid with redirect_valid.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  output  32  request address, equal to the PC register.
REQ-008 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-010 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-011 SHALL have port if_valid  output  1  instruction available to decode.
REQ-012 SHALL have port if_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port if_inst  output  32  instruction word.
REQ-014 SHALL have port if_pc  output  32  address of if_inst.
REQ-015 SHALL have port if_pc4  output  32  if_pc + 4, modulo 2^32.

Function
- REQ-016 SHALL implement states IDLE, REQ, WAIT, HOLD.
- REQ-017 SHALL hold one outstanding memory request at most and one output register.
- REQ-018 IDLE: SHALL hold imem_req=0 and go to REQ on the next cycle.
- REQ-019 REQ: SHALL drive imem_req=1 and imem_addr=pc, and go to WAIT on imem_gnt=1.
- REQ-020 WAIT: on imem_rvalid=1 with the kill flag clear, SHALL load if_inst=imem_rdata, if_pc=pc, if_pc4=pc+4, set if_valid=1, set pc=pc+4, and go to HOLD.
- REQ-021 HOLD: SHALL keep if_valid=1 with outputs stable until if_valid&&if_ready, then go to REQ and clear if_valid the next cycle.
- REQ-022 Minimum latency: grant-to-if_valid is 1 cycle plus memory latency; a new request issues the cycle after the handshake.
- REQ-023 Redirect in IDLE or in REQ without a grant SHALL set pc=redirect_pc; in REQ, imem_addr changes next cycle.
- REQ-024 Redirect in the same cycle as imem_gnt SHALL set pc=redirect_pc and the kill flag, and go to WAIT.
- REQ-025 Redirect in WAIT SHALL set pc=redirect_pc and the kill flag.
- REQ-026 imem_rvalid while the kill flag is set SHALL discard the data, clear kill, and go to REQ at the redirected pc.
- REQ-027 Redirect together with imem_rvalid in WAIT SHALL discard the data and go to REQ with pc=redirect_pc.
- REQ-028 Redirect in HOLD SHALL clear if_valid next cycle and set pc=redirect_pc, then go to REQ.
- REQ-029 Redirect takes priority over a same-cycle if_ready; the held instruction counts as not consumed.
- REQ-030 pc+4 SHALL wrap 32'hFFFF_FFFC to 32'h0000_0000.
- REQ-031 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.

Reset
- REQ-032 reset=0 SHALL immediately set: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, if_valid=0, if_inst=0, if_pc=0, if_pc4=0.
- REQ-033 Reset mid-transaction SHALL abandon the outstanding request; imem_rvalid seen in IDLE SHALL be ignored.

Configuration
- REQ-034 With FETCH_ALIGN_CHECK_EN defined, SHALL add output align_err (1 bit), set when a loaded redirect_pc has bits [1:0]≠0, sticky until reset (reset value 0); fetch continues at the aligned address.
- REQ-035 Without FETCH_ALIGN_CHECK_EN, the align_err port SHALL be absent and misalignment silently masked.

Verification
- REQ-036 Release reset, grant immediately, rvalid 1 cycle later, if_ready=1 -> if_pc=0,4,8 in order; one instruction per 3 cycles.
- REQ-037 Hold if_ready=0 for 5 cycles in HOLD -> if_inst/if_pc stable, imem_req=0 throughout.
- REQ-038 redirect_valid with redirect_pc=32'h0000_0100 in WAIT -> old rdata dropped; next imem_addr=32'h100; next if_pc=32'h100.
- REQ-039 redirect together with if_ready in HOLD -> no further if_valid for the old PC; next request at the target.
- REQ-040 Redirect to 32'hFFFF_FFFC, fetch two instructions -> if_pc=32'hFFFF_FFFC then 32'h0000_0000.
- REQ-041 With FETCH_ALIGN_CHECK_EN, redirect to 32'h0000_0102 -> imem_addr=32'h100, align_err=1 until reset.
